// File: rtl/cn_host_seq.sv
// cn_host_seq: host-side initiator that loads the scratchpad, programs and starts the
// CryptoNight core, waits for completion and streams the scratchpad back out.
module cn_host_seq #(
  parameter int ADDR_WIDTH = 15,
  parameter int RD_LATENCY = 2,
  parameter int TIMEOUT    = 1 << 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [127:0]          cmd_ax0,
  input  logic [127:0]          cmd_bx0,
  input  logic [127:0]          cmd_bx1,
  input  logic [ADDR_WIDTH+2:0] cmd_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic [7:0]            reg_address,
  output logic                  reg_write,
  output logic [31:0]           reg_wrdata,
  output logic [ADDR_WIDTH+1:0] mem_address,
  output logic                  mem_write,
  output logic [127:0]          mem_wrdata,
  input  logic [127:0]          mem_rddata,
  input  logic                  sts_ml_finished
);
  localparam int CW = ADDR_WIDTH + 3;
  localparam int MW = ADDR_WIDTH + 2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAXW = CW'(1) << MW;

  typedef enum logic [3:0] {
    IDLE, LOAD, REGS, START, WAIT, UNLOAD_ADDR, UNLOAD_WAIT, UNLOAD_OUT, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   words_q, words_d, idx_q, idx_d;
  logic [383:0]    st_q, st_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            fin_q;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic            out_valid_q, out_valid_d;
  logic [127:0]    out_data_q, out_data_d;
  logic            reg_write_q, reg_write_d;
  logic [7:0]      reg_address_q, reg_address_d;
  logic [31:0]     reg_wrdata_q, reg_wrdata_d;
  logic            mem_write_q, mem_write_d;
  logic [MW-1:0]   mem_address_q, mem_address_d;
  logic [127:0]    mem_wrdata_q, mem_wrdata_d;
  logic            hs, rise;

  assign in_ready    = (state_q == LOAD) && (idx_q < words_q);
  assign hs          = in_valid && in_ready;
  assign rise        = sts_ml_finished && !fin_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign reg_write   = reg_write_q;
  assign reg_address = reg_address_q;
  assign reg_wrdata  = reg_wrdata_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wrdata  = mem_wrdata_q;

  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    st_d        = st_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    error_d     = error_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: if (cmd_start) begin
        words_d = (cmd_words > MAXW) ? MAXW : cmd_words;
        st_d    = {cmd_bx1, cmd_bx0, cmd_ax0};
        error_d = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = (cmd_words == '0) ? REGS : LOAD;
      end
      LOAD: begin
        idx_d   = idx_q + CW'(hs);
        state_d = (idx_q == words_q) ? REGS : LOAD;
      end
      REGS: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd11) ? START : REGS;
      end
      START: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: if (rise) begin
        idx_d   = '0;
        state_d = (words_q == '0) ? DONE : UNLOAD_ADDR;
      end else if (wait_q == TW'(TIMEOUT - 1)) begin
        error_d = 1'b1;
        state_d = DONE;
      end else begin
        wait_d = wait_q + TW'(1);
      end
      UNLOAD_ADDR: begin
        cnt_d   = '0;
        state_d = UNLOAD_WAIT;
      end
      UNLOAD_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(RD_LATENCY - 1)) begin
          out_data_d  = mem_rddata;
          out_valid_d = 1'b1;
          state_d     = UNLOAD_OUT;
        end
      end
      UNLOAD_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        idx_d       = idx_q + CW'(1);
        state_d     = (idx_q == words_q - CW'(1)) ? DONE : UNLOAD_ADDR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered outputs are decoded from the next state so they line up with the state they belong to
    busy_d        = !(state_d inside {IDLE, DONE});
    done_d        = state_d == DONE;
    reg_write_d   = state_d inside {REGS, START};
    reg_address_d = (state_d == START) ? 8'h0C : (state_d == REGS) ? 8'(cnt_d) : reg_address_q;
    reg_wrdata_d  = (state_d == START) ? 32'h1 : (state_d == REGS) ? st_d[32*cnt_d +: 32] : reg_wrdata_q;
    mem_write_d   = hs;
    mem_address_d = hs ? idx_q[MW-1:0] : (state_d == UNLOAD_ADDR) ? idx_d[MW-1:0] : mem_address_q;
    mem_wrdata_d  = hs ? in_data : mem_wrdata_q;
  end

  always_ff @(posedge clk) begin
    fin_q <= sts_ml_finished;
    if (reset) begin
      state_q       <= IDLE;
      words_q       <= '0;
      st_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      reg_write_q   <= 1'b0;
      reg_address_q <= '0;
      reg_wrdata_q  <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wrdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      words_q       <= words_d;
      st_q          <= st_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      reg_write_q   <= reg_write_d;
      reg_address_q <= reg_address_d;
      reg_wrdata_q  <= reg_wrdata_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wrdata_q  <= mem_wrdata_d;
    end
  end
endmodule

// File: tb/tb_cn_host_seq.sv
// tb_cn_host_seq: scoreboard bench for cn_host_seq with a memory/core responder model.
module tb_cn_host_seq;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int TO = 200;
  localparam int NMAX = 64;

  logic clk = 0, reset = 1, cmd_start = 0, sts = 0;
  logic [127:0] cmd_ax0 = 0, cmd_bx0 = 0, cmd_bx1 = 0;
  logic [AW+2:0] cmd_words = 0;
  logic busy, done, error, in_ready, out_valid, reg_write, mem_write;
  logic in_valid = 0, out_ready = 0;
  logic [127:0] in_data = 0, out_data, mem_wrdata, mem_rddata;
  logic [7:0] reg_address;
  logic [31:0] reg_wrdata;
  logic [AW+1:0] mem_address;

  always #5 clk = ~clk;

  cn_host_seq #(.ADDR_WIDTH(AW), .RD_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_ax0(cmd_ax0), .cmd_bx0(cmd_bx0),
    .cmd_bx1(cmd_bx1), .cmd_words(cmd_words), .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .reg_address(reg_address), .reg_write(reg_write),
    .reg_wrdata(reg_wrdata), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata), .sts_ml_finished(sts)
  );

  // Scratchpad responder: writes land immediately, reads return RL=2 cycles after the address
  logic [127:0] mem [NMAX];
  logic [127:0] p1 = 0, p2 = 0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_wrdata;
    p1 <= mem[mem_address];
    p2 <= p1;
  end
  assign mem_rddata = p2;

  logic [133:0] memq[$];
  logic [39:0]  regq[$];
  logic [127:0] outq[$];
  int n_chk = 0, n_fail = 0, start_cnt = 0, done_cnt = 0;
  bit mon_en = 1, prev_stall = 0;
  logic [127:0] prev_data = 0;

  task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic unexp(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT output present, none required", name);
  endtask

  function automatic logic [127:0] wd(input int job, input int k);
    return {32'(job), 32'(k), 32'(k) * 32'h9e3779b9, 32'hc0de0000 ^ 32'(job)};
  endfunction

  function automatic logic [31:0] slice(input logic [127:0] a, b, c, input int i);
    logic [383:0] s;
    s = {c, b, a};
    return s[32*i +: 32];
  endfunction

  always @(negedge clk) if (!reset) begin
    if (reg_write && reg_address == 8'h0C) start_cnt++;
    if (done) done_cnt++;
    if (mon_en) begin
      if (mem_write) begin
        if (memq.size() == 0) unexp("mem_write");
        else check("mem_write", {mem_address, mem_wrdata}, memq.pop_front());
      end
      if (reg_write) begin
        if (regq.size() == 0) unexp("reg_write");
        else check("reg_write", {reg_address, reg_wrdata}, regq.pop_front());
      end
      if (out_valid && out_ready) begin
        if (outq.size() == 0) unexp("out_word");
        else check("out_word", out_data, outq.pop_front());
      end
      if (prev_stall) begin
        check("out_hold_valid", out_valid, 1);
        check("out_hold_data", out_data, prev_data);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic reset_check();
    check("rst_ctrl", {busy, done, error, in_ready, out_valid, reg_write, mem_write}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_reg", {reg_address, reg_wrdata}, 0);
    check("rst_mem", {mem_address, mem_wrdata}, 0);
  endtask

  // mode 0: finished rises 100 cycles into WAIT; 1: held high before start, falls then rises; 2: never rises
  task automatic run_job(input int job, input int nreq, input logic [127:0] a, b, c,
                         input bit bp, input int mode);
    int n, k, g, s0, d0;
    n = nreq > NMAX ? NMAX : nreq;
    for (int i = 0; i < n; i++) begin
      memq.push_back({6'(i), wd(job, i)});
      if (mode != 2) outq.push_back(wd(job, i));
    end
    for (int i = 0; i < 12; i++) regq.push_back({8'(i), slice(a, b, c, i)});
    regq.push_back({8'h0C, 32'h1});
    s0 = start_cnt;
    d0 = done_cnt;
    sts = (mode == 1);
    @(posedge clk); #1;
    cmd_start = 1; cmd_words = 7'(nreq); cmd_ax0 = a; cmd_bx0 = b; cmd_bx1 = c;
    @(posedge clk); #1;
    cmd_start = 0; cmd_ax0 = ~a; cmd_bx0 = ~b; cmd_bx1 = ~c; cmd_words = 7'd3;
    check("busy_rise", busy, 1);
    check("error_clear", error, 0);
    k = 0; g = 0;
    while (k < n && g < 2000) begin
      in_valid  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = wd(job, k);
      cmd_start = (k == n / 2);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 0; cmd_start = 0;
    g = 0;
    while (start_cnt == s0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check("start_seen", start_cnt - s0, 1);
    cmd_start = 1;
    @(posedge clk); #1;
    cmd_start = 0;
    if (mode == 0) begin
      repeat (100) @(posedge clk);
      #1 sts = 1;
    end else if (mode == 1) begin
      repeat (40) @(posedge clk);
      #1 check("wait_level_held", {busy, out_valid}, 2'b10);
      sts = 0;
      repeat (20) @(posedge clk);
      #1 sts = 1;
    end
    g = 0;
    while (done_cnt == d0 && g < 5000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      g++;
    end
    out_ready = 0; sts = 0;
    repeat (3) @(posedge clk);
    #1 check("done_once", done_cnt - d0, 1);
    check("busy_end", busy, 0);
    check("error_flag", error, mode == 2);
    check("sb_empty", {32'(memq.size()), 32'(regq.size()), 32'(outq.size())}, 0);
  endtask

  task automatic abort_job(input int job, input bit unload);
    int k, g, s0;
    mon_en = 0;
    s0 = start_cnt;
    @(posedge clk); #1;
    cmd_start = 1; cmd_words = 7'd8; cmd_ax0 = wd(job, 100);
    @(posedge clk); #1;
    cmd_start = 0;
    k = 0; g = 0;
    while (k < (unload ? 8 : 3) && g < 200) begin
      in_valid = 1;
      in_data  = wd(job, k);
      if (in_ready) k++;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 0;
    if (unload) begin
      g = 0;
      while (start_cnt == s0 && g < 500) begin
        @(posedge clk); #1;
        g++;
      end
      @(posedge clk); #1;
      sts = 1;
      g = 0;
      while (!out_valid && g < 500) begin
        @(posedge clk); #1;
        g++;
      end
      check("reached_unload", out_valid, 1);
    end else begin
      check("reached_load", in_ready, 1);
    end
    reset = 1;
    @(posedge clk); #1;
    reset_check();
    reset = 0; sts = 0;
    memq.delete(); regq.delete(); outq.delete();
    prev_stall = 0;
    mon_en = 1;
  endtask

  initial begin
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset_check();
    reset = 0;
    run_job(1, 64, 128'h0123456789abcdef0123456789abcdef, 128'h00112233445566778899aabbccddeeff,
            128'hfedcba9876543210f0e1d2c3b4a59687, 0, 0);
    run_job(2, 64, 128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888,
            128'h99999999aaaaaaaabbbbbbbbcccccccc, 1, 0);
    run_job(3, 0, 128'hdeadbeef0badf00dcafebabe12345678, 128'h1, 128'h2, 0, 0);
    run_job(4, 8, 128'ha5a5a5a5, 128'h5a5a5a5a00000000, 128'h3c3c3c3c, 0, 1);
    run_job(5, 8, 128'h77, 128'h88, 128'h99, 0, 2);
    run_job(6, 70, 128'h0f0f0f0f_f0f0f0f0_12121212_34343434, 128'h6, 128'h7, 1, 0);
    abort_job(7, 0);
    run_job(8, 16, 128'habcdef, 128'h123456, 128'h789abc, 1, 0);
    abort_job(9, 1);
    run_job(10, 5, 128'h1000, 128'h2000, 128'h3000, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
